cam_wr_arbiter: RTL and testbench
=================================

CAM_WR_ARBITER -- requirements
Module: cam_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: CAM search/write data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3: CAM address width; entry count N = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 4: cycles to wait for CAM busy assertion after issue.
REQ-004 SHALL use one clock and an asynchronous active-low reset.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 reqN_valid  in  1  requester N (N=0,1) has an operation pending.
REQ-008 reqN_ready  out  1  one-cycle pulse: requester N's operation accepted.
REQ-009 reqN_delete  in  1  0 = write entry, 1 = delete entry.
REQ-010 reqN_addr  in  ADDR_WIDTH  target CAM entry.
REQ-011 reqN_data  in  DATA_WIDTH  write data (ignored for delete).
REQ-012 reqN_done  out  1  one-cycle pulse: requester N's operation completed.
REQ-013 reqN_err  out  1  valid with reqN_done; 1 = CAM busy never asserted (timeout).
REQ-014 cam_write_addr / cam_write_data  out  ADDR_WIDTH / DATA_WIDTH  CAM write port.
REQ-015 cam_write_enable / cam_write_delete  out  1 / 1  CAM operation strobes.
REQ-016 cam_write_busy  in  1  CAM write-side busy.
REQ-017 valid_map  out  N  occupied entries; occ_count  out  ADDR_WIDTH+1  number of set bits.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-019 IDLE: when cam_write_busy=0 and any reqN_valid=1, grant one requester, pulse its reqN_ready, latch its delete/addr/data, go to ISSUE; while cam_write_busy=1, grant none.
REQ-020 Arbitration round-robin: priority pointer = 0 after reset; after each grant pointer = other port; single requester always granted regardless of pointer.
REQ-021 ISSUE (exactly one cycle): drive latched addr/data; cam_write_enable=~delete, cam_write_delete=delete; never both high; go to WAIT_ACK.
REQ-022 cam_write_enable/cam_write_delete SHALL be 0 in every state other than ISSUE; cam_write_addr/data hold latched values.
REQ-023 WAIT_ACK: if cam_write_busy=1 go to WAIT_DONE; if ACK_TIMEOUT cycles elapse without it, pulse reqN_done with reqN_err=1, go to IDLE.
REQ-024 WAIT_DONE: on cam_write_busy=0 pulse reqN_done with reqN_err=0 and go to IDLE; no timeout.
REQ-025 Minimum accept-to-done latency 4 cycles (accept T, issue T+1, busy seen T+2, done when busy falls).
REQ-026 Only one operation outstanding; reqN_ready SHALL not pulse outside IDLE grants.
REQ-027 Requester N dropping reqN_valid after accept does not cancel the operation.
REQ-028 reqN_done/reqN_err of the non-granted port stay 0.

Reset
REQ-029 On rst_n=0 (asynchronous): state IDLE, pointer 0, all strobes/ready/done/err 0, latched addr/data 0, valid_map 0, occ_count 0.
REQ-030 Reset mid-operation abandons it: no reqN_done for the dropped operation.

Configuration
REQ-031 Macro CAM_WR_ARBITER_OCCUPANCY_EN defined: on successful done (err=0) set valid_map[addr] for write, clear for delete; occ_count = popcount(valid_map), updated same edge.
REQ-032 Macro undefined: valid_map and occ_count tied 0; all other behaviour identical.

Verification
REQ-033 Post-reset cam_write_busy=1 for 10 cycles, req0_valid=1 -> no ready until busy=0, then req0_ready pulse, single cam_write_enable pulse next cycle.
REQ-034 req0 and req1 valid continuously, CAM busy 3 cycles per op -> grants alternate 0,1,0,1; done count per port equal.
REQ-035 req1 delete addr=5 -> cam_write_delete=1, cam_write_enable=0, cam_write_addr=5 for one cycle; req1_done err=0.
REQ-036 CAM model never raises busy -> req0_done with req0_err=1 exactly ACK_TIMEOUT cycles after WAIT_ACK entry.
REQ-037 With macro: write addr 2, write addr 6, delete addr 2 -> valid_map=8'h40, occ_count=1; without macro both 0.
REQ-038 rst_n low during WAIT_DONE -> outputs zero immediately, no done pulse, next request served normally.

Source files
------------

// File: rtl/cam_wr_arbiter.sv
// cam_wr_arbiter: two-port round-robin arbiter feeding a CAM write port with ack/done handshake.
// Optional occupancy tracking (valid_map/occ_count) is enabled by defining CAM_WR_ARBITER_OCCUPANCY_EN.
module cam_wr_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 3,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic                    req0_delete,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_data,
  output logic                    req0_done,
  output logic                    req0_err,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic                    req1_delete,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_data,
  output logic                    req1_done,
  output logic                    req1_err,
  output logic [ADDR_WIDTH-1:0]   cam_write_addr,
  output logic [DATA_WIDTH-1:0]   cam_write_data,
  output logic                    cam_write_enable,
  output logic                    cam_write_delete,
  input  logic                    cam_write_busy,
  output logic [2**ADDR_WIDTH-1:0] valid_map,
  output logic [ADDR_WIDTH:0]     occ_count
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
  state_t                state;
  logic                  ptr;
  logic                  owner;
  logic [CW-1:0]         cnt;
  logic                  grant_any;
  logic                  grant1;
  logic                  sel_del;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  // Accept only from IDLE with the CAM quiet; port 1 wins when alone or when it holds priority.
  assign grant_any  = rst_n && state == IDLE && !cam_write_busy && (req0_valid || req1_valid);
  assign grant1     = req1_valid && (!req0_valid || ptr);
  assign req0_ready = grant_any && !grant1;
  assign req1_ready = grant_any && grant1;
  assign sel_del    = grant1 ? req1_delete : req0_delete;
  assign sel_addr   = grant1 ? req1_addr : req0_addr;
  assign sel_data   = grant1 ? req1_data : req0_data;
  // Operation sequencer: latch, one-cycle strobe, wait for busy rise (bounded), wait for busy fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      ptr              <= 1'b0;
      owner            <= 1'b0;
      cnt              <= '0;
      cam_write_addr   <= '0;
      cam_write_data   <= '0;
      cam_write_enable <= 1'b0;
      cam_write_delete <= 1'b0;
      req0_done        <= 1'b0;
      req1_done        <= 1'b0;
      req0_err         <= 1'b0;
      req1_err         <= 1'b0;
    end else begin
      cam_write_enable <= 1'b0;
      cam_write_delete <= 1'b0;
      req0_done        <= 1'b0;
      req1_done        <= 1'b0;
      req0_err         <= 1'b0;
      req1_err         <= 1'b0;
      case (state)
        IDLE: if (grant_any) begin
          owner            <= grant1;
          ptr              <= ~grant1;
          cam_write_addr   <= sel_addr;
          cam_write_data   <= sel_data;
          cam_write_enable <= ~sel_del;
          cam_write_delete <= sel_del;
          state            <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: if (cam_write_busy) state <= WAIT_DONE;
        else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          req0_done <= ~owner;
          req1_done <= owner;
          req0_err  <= ~owner;
          req1_err  <= owner;
          state     <= IDLE;
        end else cnt <= cnt + 1'b1;
        WAIT_DONE: if (!cam_write_busy) begin
          req0_done <= ~owner;
          req1_done <= owner;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CAM_WR_ARBITER_OCCUPANCY_EN
  logic                    del;
  logic [2**ADDR_WIDTH-1:0] map_nxt;
  // Map after the in-flight operation lands: write sets the entry, delete clears it.
  always_comb begin
    map_nxt                 = valid_map;
    map_nxt[cam_write_addr] = ~del;
  end
  // Commit occupancy only on a successful completion, alongside the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      del       <= 1'b0;
      valid_map <= '0;
      occ_count <= '0;
    end else begin
      if (grant_any) del <= sel_del;
      if (state == WAIT_DONE && !cam_write_busy) begin
        valid_map <= map_nxt;
        occ_count <= (ADDR_WIDTH + 1)'($countones(map_nxt));
      end
    end
  end
`else
  assign valid_map = '0;
  assign occ_count = '0;
`endif
endmodule

// File: tb/tb_cam_wr_arbiter.sv
// tb_cam_wr_arbiter: randomized scoreboard bench with a transaction-level CAM/arbiter model.
module tb_cam_wr_arbiter;
  localparam int TO = 4;
  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req0_ready, req0_delete = 0, req0_done, req0_err;
  logic req1_valid = 0, req1_ready, req1_delete = 0, req1_done, req1_err;
  logic [2:0] req0_addr = 0, req1_addr = 0, cam_write_addr;
  logic [15:0] req0_data = 0, req1_data = 0, cam_write_data;
  logic cam_write_enable, cam_write_delete, cam_write_busy = 0;
  logic [7:0] valid_map;
  logic [3:0] occ_count;
  typedef struct {bit del; logic [2:0] a; logic [15:0] d;} op_t;
  op_t q0[$], q1[$];
  int n_checks = 0, n_fails = 0;
  int cyc = 0, vmode = 3, cmode = 1, force_busy = 0, errs_seen = 0;
  int dcnt[2] = '{0, 0};
  bit pend = 0, odel = 0, silent = 0, ptr_m = 0;
  int own = 0, acc = 0, bfrom = 0, bto = 0, edone = 0;
  logic [2:0] oaddr = 0, laddr = 0;
  logic [15:0] odata = 0, ldata = 0;
  bit [7:0] map_m = 0;
  cam_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_delete(req0_delete),
    .req0_addr(req0_addr), .req0_data(req0_data), .req0_done(req0_done), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_delete(req1_delete),
    .req1_addr(req1_addr), .req1_data(req1_data), .req1_done(req1_done), .req1_err(req1_err),
    .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
    .cam_write_enable(cam_write_enable), .cam_write_delete(cam_write_delete),
    .cam_write_busy(cam_write_busy), .valid_map(valid_map), .occ_count(occ_count)
  );
  initial forever #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_rdy0"}, 64'(req0_ready), 0);
    check({tag, "_rdy1"}, 64'(req1_ready), 0);
    check({tag, "_done0"}, 64'(req0_done), 0);
    check({tag, "_done1"}, 64'(req1_done), 0);
    check({tag, "_err0"}, 64'(req0_err), 0);
    check({tag, "_err1"}, 64'(req1_err), 0);
    check({tag, "_en"}, 64'(cam_write_enable), 0);
    check({tag, "_del"}, 64'(cam_write_delete), 0);
    check({tag, "_addr"}, 64'(cam_write_addr), 0);
    check({tag, "_data"}, 64'(cam_write_data), 0);
    check({tag, "_map"}, 64'(valid_map), 0);
    check({tag, "_occ"}, 64'(occ_count), 0);
  endtask
  task automatic drive();
    op_t o0, o1;
    bit v0, v1;
    v0 = vmode == 0 ? bit'($urandom_range(0, 1)) : (vmode == 1 || vmode == 2);
    v1 = vmode == 0 ? bit'($urandom_range(0, 1)) : (vmode == 1);
    o0 = '{bit'($urandom_range(0, 1)), 3'($urandom), 16'($urandom)};
    o1 = '{bit'($urandom_range(0, 1)), 3'($urandom), 16'($urandom)};
    if (q0.size() > 0) begin v0 = 1; o0 = q0[0]; end
    if (q1.size() > 0) begin v1 = 1; o1 = q1[0]; end
    req0_valid = v0; req0_delete = o0.del; req0_addr = o0.a; req0_data = o0.d;
    req1_valid = v1; req1_delete = o1.del; req1_addr = o1.a; req1_data = o1.d;
    if (!pend && force_busy == 0 && vmode == 0 && $urandom_range(0, 19) == 0)
      force_busy = int'($urandom_range(1, 3));
    if (pend) cam_write_busy = !silent && cyc >= bfrom && cyc <= bto;
    else begin
      cam_write_busy = force_busy > 0;
      if (force_busy > 0) force_busy--;
    end
  endtask
  task automatic evaluate();
    bit d, g, g1, iss;
    bit [7:0] em;
    int pc, dl, ln;
    d = pend && cyc == edone;
    check("done0", 64'(req0_done), 64'(d && own == 0));
    check("done1", 64'(req1_done), 64'(d && own == 1));
    check("err0", 64'(req0_err), 64'(d && own == 0 && silent));
    check("err1", 64'(req1_err), 64'(d && own == 1 && silent));
    if (d) begin
      pend = 0;
      dcnt[own]++;
      if (silent) errs_seen++;
      else map_m[oaddr] = !odel;
    end
    iss = pend && cyc == acc + 1;
    check("wr_en", 64'(cam_write_enable), 64'(iss && !odel));
    check("wr_del", 64'(cam_write_delete), 64'(iss && odel));
    check("wr_addr", 64'(cam_write_addr), 64'(laddr));
    check("wr_data", 64'(cam_write_data), 64'(ldata));
    g = !pend && !cam_write_busy && (req0_valid || req1_valid);
    g1 = req1_valid && (!req0_valid || ptr_m);
    check("ready0", 64'(req0_ready), 64'(g && !g1));
    check("ready1", 64'(req1_ready), 64'(g && g1));
    if (g) begin
      own = g1 ? 1 : 0;
      odel = g1 ? req1_delete : req0_delete;
      oaddr = g1 ? req1_addr : req0_addr;
      odata = g1 ? req1_data : req0_data;
      laddr = oaddr; ldata = odata;
      pend = 1; acc = cyc; ptr_m = !g1;
      if (g1 && q1.size() > 0) void'(q1.pop_front());
      if (!g1 && q0.size() > 0) void'(q0.pop_front());
      silent = cmode == 2 || (cmode == 0 && $urandom_range(0, 4) == 0);
      dl = cmode == 1 ? 0 : int'($urandom_range(0, TO - 1));
      ln = cmode == 1 ? 3 : int'($urandom_range(1, 4));
      bfrom = acc + 2 + dl;
      bto = bfrom + ln - 1;
      edone = silent ? acc + 2 + TO : bto + 2;
    end
`ifdef CAM_WR_ARBITER_OCCUPANCY_EN
    em = map_m;
`else
    em = 0;
`endif
    pc = 0;
    for (int i = 0; i < 8; i++) pc += int'(em[i]);
    check("valid_map", 64'(valid_map), 64'(em));
    check("occ_count", 64'(occ_count), 64'(pc));
  endtask
  task automatic cycle();
    @(posedge clk);
    cyc++;
    #1 drive();
    @(negedge clk);
    evaluate();
  endtask
  task automatic drain();
    vmode = 3;
    for (int i = 0; i < 60 && pend; i++) cycle();
    check("drain_bound", 64'(pend), 0);
  endtask
  initial begin
    int b0, b1, be;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    rst_n = 1;
    // busy held after reset: no grant until it clears, then one write strobe
    force_busy = 10; vmode = 2; cmode = 1;
    repeat (20) cycle();
    drain();
    // both requesters continuously valid: alternating grants
    b0 = dcnt[0]; b1 = dcnt[1]; vmode = 1;
    for (int i = 0; i < 200 && dcnt[0] + dcnt[1] - b0 - b1 < 6; i++) cycle();
    check("rr_done0", 64'(dcnt[0] - b0), 3);
    check("rr_done1", 64'(dcnt[1] - b1), 3);
    drain();
    // delete of entry 5 from requester 1
    b1 = dcnt[1];
    q1.push_back('{1'b1, 3'd5, 16'h1234});
    for (int i = 0; i < 50 && dcnt[1] == b1; i++) cycle();
    check("del5_done", 64'(dcnt[1] - b1), 1);
    // silent CAM: timeout with error
    be = errs_seen; cmode = 2;
    q0.push_back('{1'b0, 3'd1, 16'hbeef});
    for (int i = 0; i < 50 && errs_seen == be; i++) cycle();
    check("timeout_err", 64'(errs_seen - be), 1);
    drain();
    // reset while waiting for busy to fall
    cmode = 1;
    q0.push_back('{1'b0, 3'd3, 16'h5a5a});
    for (int i = 0; i < 50 && !(pend && cyc == acc + 3); i++) cycle();
    check("wait_done_bound", 64'(pend && cyc == acc + 3), 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1 check_zero("midop_reset");
    pend = 0; ptr_m = 0; laddr = 0; ldata = 0; map_m = 0; force_busy = 0;
    q0.delete(); q1.delete();
    req0_valid = 0; req1_valid = 0; cam_write_busy = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // occupancy: write 2, write 6, delete 2
    b0 = dcnt[0]; vmode = 3; cmode = 1;
    q0.push_back('{1'b0, 3'd2, 16'h0002});
    q0.push_back('{1'b0, 3'd6, 16'h0006});
    q0.push_back('{1'b1, 3'd2, 16'h0000});
    for (int i = 0; i < 100 && dcnt[0] - b0 < 3; i++) cycle();
    check("occ_ops", 64'(dcnt[0] - b0), 3);
`ifdef CAM_WR_ARBITER_OCCUPANCY_EN
    check("occ_map", 64'(valid_map), 64'h40);
    check("occ_cnt", 64'(occ_count), 1);
`else
    check("occ_map", 64'(valid_map), 0);
    check("occ_cnt", 64'(occ_count), 0);
`endif
    // random traffic with random CAM response and idle busy bursts
    vmode = 0; cmode = 0;
    repeat (3000) cycle();
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
